mc_control: RTL
===============

MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 The block SHALL take parameters, one per line:
- NUM_INST_W, 16, width of the retired-instruction counter.
- ALUOP_W, 4, width of alu_op.
REQ-002 The block SHALL have one clock, clk, and an asynchronous active-low reset, reset_n.
REQ-003 The block SHALL have these ports, one per line:
- clk  in  1  clock.
- reset_n  in  1  async active-low reset.
- opcode  in  4  IR[15:12].
- func_code  in  6  IR[5:0].
- mem_ready  in  1  memory access complete this cycle.
- alu_bcond  in  1  branch condition from the ALU.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load when alu_bcond=1.
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 register rs.
- i_or_d  out  1  0 instruction address, 1 data address.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  IR load.
- reg_write  out  1  register file write.
- reg_dst  out  2  00 rt, 01 rd, 10 $2.
- mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC.
- alu_src_a  out  1  0 PC, 1 rs.
- alu_src_b  out  2  00 rt, 01 constant 1, 10 sign-extended immediate.
- alu_op  out  ALUOP_W  operation select.
- is_wwd  out  1  output-port write.
- is_halted  out  1  CPU halted.
- num_inst  out  NUM_INST_W  retired-instruction count.
- state  out  4  current state, for debug.

Function
REQ-004 Encodings SHALL be as follows:
- opcode: BNE 0, BEQ 1, BGZ 2, BLZ 3, ADI 4, ORI 5, LHI 6, LWD 7, SWD 8, JMP 9, JAL 10, R-type 15.
- R-type func_code: ALU 0-7, JPR 25, JRL 26, WWD 28, HLT 29.
- alu_op: ADD 0, SUB 1, AND 2, ORR 3, NOT 4, TCP 5, SHL 6, SHR 7, LHI 8, ID 9, BNE 10, BEQ 11, BGZ 12, BLZ 13.
REQ-005 The states SHALL be IF 0, ID 1, EX 2, MEM 3, WB 4 and HALT 5, held in one registered state variable.
REQ-006 All outputs SHALL be combinational from state, opcode, func_code and mem_ready; unlisted strobes are 0 and unlisted selects are 0 in every state.
REQ-007 IF state:
- Drive mem_read=1 and i_or_d=0.
- Hold IF while mem_ready=0.
- When mem_ready=1, assert ir_write, pc_write, alu_src_b=01 and alu_op=ADD (PC+1), then go to ID.
REQ-008 ID state:
- Always drive alu_src_b=10 and alu_op=ADD, computing the branch target into ALUOut.
- JMP: pc_write=1, pc_source=10.
- JAL: as JMP, plus reg_write=1, reg_dst=10, mem_to_reg=10.
- JPR: pc_write=1, pc_source=11.
- JRL: as JPR, plus the JAL register write.
- WWD: is_wwd=1.
- Each of these retires and returns to IF.
REQ-009 ID with HLT SHALL retire and go to HALT; ID with an undefined opcode or func_code SHALL retire as a NOP and return to IF.
REQ-010 EX state:
- R-type ALU ops: alu_src_a=1, alu_src_b=00, alu_op=func_code[3:0], then WB.
- ADI, ORI, LHI: alu_src_a=1, alu_src_b=10, alu_op ADD, ORR or LHI respectively, then WB.
- LWD, SWD: alu_src_a=1, alu_src_b=10, alu_op=ADD, then MEM.
- Branches: alu_src_a=1, alu_src_b=00, alu_op=10+opcode, pc_write_cond=1, pc_source=01; the branch retires and returns to IF.
REQ-011 MEM state:
- Drive i_or_d=1.
- mem_read=1 for LWD; mem_write=1 for SWD.
- Hold MEM while mem_ready=0.
- On mem_ready=1, LWD goes to WB; SWD retires and goes to IF.
REQ-012 WB state:
- Drive reg_write=1.
- reg_dst=01 for R-type, 00 otherwise.
- mem_to_reg=01 for LWD, 00 otherwise.
- Retire, then go to IF.
REQ-013 HALT state SHALL drive is_halted=1 with all strobes 0, and SHALL remain there until reset.
REQ-014 Retiring SHALL increment num_inst by 1 on the clock edge leaving the retiring state; the increment wraps modulo 2^NUM_INST_W.
REQ-015 mem_ready asserted outside IF or MEM SHALL be ignored.

Reset
REQ-016 While reset_n=0 the block SHALL asynchronously set state=IF and num_inst=0.
REQ-017 While reset_n=0 every strobe SHALL be forced to 0, including mem_write during an interrupted MEM access.
REQ-018 After reset release, the first rising clk edge SHALL be treated as a normal IF cycle.

Verification
REQ-019 ADI, opcode 4, with mem_ready=1 in IF:
- Sequence is IF, ID, EX, WB, IF.
- WB shows reg_write=1 and reg_dst=00.
- num_inst goes 0 to 1.
REQ-020 LWD, opcode 7, with mem_ready held low for 3 cycles in MEM:
- The bench sees MEM for 4 cycles with mem_read=1 and i_or_d=1.
- Then WB with mem_to_reg=01.
REQ-021 BEQ, opcode 1, with alu_bcond=1:
- EX shows pc_write_cond=1, pc_source=01 and alu_op=11.
- The next state is IF.
REQ-022 JAL, opcode 10:
- ID shows pc_write=1, pc_source=10, reg_write=1, reg_dst=10 and mem_to_reg=10.
- EX is never entered.
REQ-023 HLT, func_code 29, followed by 10 cycles with mem_ready=1:
- is_halted=1 and state=5 throughout.
- num_inst increments exactly once.
REQ-024 reset_n pulsed low during MEM of SWD:
- mem_write drops immediately.
- state=0 and num_inst=0.
- With NUM_INST_W=2, four WWD instructions (func_code 28) return num_inst to 0.

Source files
------------

// File: rtl/mc_control_if.sv
// Control bundle between the multicycle controller and its datapath.
// The controller drives the strobes and selects; the datapath supplies the IR fields and memory/ALU status.
interface mc_control_if #(
    parameter int NUM_INST_W = 16,
    parameter int ALUOP_W    = 4
);
    logic [3:0]            opcode;
    logic [5:0]            func_code;
    logic                  mem_ready;
    logic                  alu_bcond;
    logic                  pc_write;
    logic                  pc_write_cond;
    logic [1:0]            pc_source;
    logic                  i_or_d;
    logic                  mem_read;
    logic                  mem_write;
    logic                  ir_write;
    logic                  reg_write;
    logic [1:0]            reg_dst;
    logic [1:0]            mem_to_reg;
    logic                  alu_src_a;
    logic [1:0]            alu_src_b;
    logic [ALUOP_W-1:0]    alu_op;
    logic                  is_wwd;
    logic                  is_halted;
    logic [NUM_INST_W-1:0] num_inst;
    logic [3:0]            state;
    logic                  pc_load;

    // Effective PC load as seen by the datapath: unconditional or taken branch.
    assign pc_load = pc_write | (pc_write_cond & alu_bcond);

    modport master (
        input  opcode, func_code, mem_ready,
        output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
               ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
               alu_op, is_wwd, is_halted, num_inst, state
    );

    modport slave (
        output opcode, func_code, mem_ready, alu_bcond,
        input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
               ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
               alu_op, is_wwd, is_halted, num_inst, state, pc_load
    );
endinterface

// File: rtl/mc_control.sv
// Multicycle CPU controller: IF/ID/EX/MEM/WB/HALT sequencer with a retired-instruction counter.
// Outputs are decoded combinationally from the current state and IR fields, and are all zero in reset.
module mc_control #(
    parameter int NUM_INST_W = 16,
    parameter int ALUOP_W    = 4
) (
    input logic        clk,
    input logic        reset_n,
    mc_control_if.master bus
);
    typedef enum logic [3:0] {
        S_IF   = 4'd0,
        S_ID   = 4'd1,
        S_EX   = 4'd2,
        S_MEM  = 4'd3,
        S_WB   = 4'd4,
        S_HALT = 4'd5
    } state_t;

    localparam logic [3:0] OP_LHI  = 4'd6;
    localparam logic [3:0] OP_ORI  = 4'd5;
    localparam logic [3:0] OP_ADI  = 4'd4;
    localparam logic [3:0] OP_LWD  = 4'd7;
    localparam logic [3:0] OP_SWD  = 4'd8;
    localparam logic [3:0] OP_JMP  = 4'd9;
    localparam logic [3:0] OP_JAL  = 4'd10;
    localparam logic [3:0] OP_RTYP = 4'd15;
    localparam logic [5:0] FN_JPR  = 6'd25;
    localparam logic [5:0] FN_JRL  = 6'd26;
    localparam logic [5:0] FN_WWD  = 6'd28;
    localparam logic [5:0] FN_HLT  = 6'd29;

    state_t                state_q, state_d;
    logic                  retire;
    logic [NUM_INST_W-1:0] num_inst_q;

    logic is_rtype, is_alu_r, is_branch, is_imm, is_lwd, is_swd;
    logic is_jmp, is_jal, is_jpr, is_jrl, is_wwd_i, is_hlt, needs_ex;

    assign is_rtype  = (bus.opcode == OP_RTYP);
    assign is_alu_r  = is_rtype && (bus.func_code[5:3] == 3'd0);
    assign is_branch = (bus.opcode[3:2] == 2'b00);
    assign is_imm    = (bus.opcode == OP_ADI) || (bus.opcode == OP_ORI) || (bus.opcode == OP_LHI);
    assign is_lwd    = (bus.opcode == OP_LWD);
    assign is_swd    = (bus.opcode == OP_SWD);
    assign is_jmp    = (bus.opcode == OP_JMP);
    assign is_jal    = (bus.opcode == OP_JAL);
    assign is_jpr    = is_rtype && (bus.func_code == FN_JPR);
    assign is_jrl    = is_rtype && (bus.func_code == FN_JRL);
    assign is_wwd_i  = is_rtype && (bus.func_code == FN_WWD);
    assign is_hlt    = is_rtype && (bus.func_code == FN_HLT);
    assign needs_ex  = is_alu_r || is_branch || is_imm || is_lwd || is_swd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IF;
            num_inst_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) num_inst_q <= num_inst_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_IF: if (bus.mem_ready) state_d = S_ID;
            S_ID: begin
                if (needs_ex) begin
                    state_d = S_EX;
                end else begin
                    // Jumps, WWD, HLT and undefined encodings all finish here.
                    state_d = is_hlt ? S_HALT : S_IF;
                    retire  = 1'b1;
                end
            end
            S_EX: begin
                if (is_branch) begin
                    state_d = S_IF;
                    retire  = 1'b1;
                end else if (is_lwd || is_swd) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (bus.mem_ready) begin
                    if (is_lwd) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_IF;
                        retire  = 1'b1;
                    end
                end
            end
            S_WB: begin
                state_d = S_IF;
                retire  = 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IF;
        endcase
    end

    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.pc_source     = 2'b00;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.reg_write     = 1'b0;
        bus.reg_dst       = 2'b00;
        bus.mem_to_reg    = 2'b00;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.alu_op        = '0;
        bus.is_wwd        = 1'b0;
        bus.is_halted     = 1'b0;
        if (reset_n) begin
            case (state_q)
                S_IF: begin
                    bus.mem_read = 1'b1;
                    if (bus.mem_ready) begin
                        bus.ir_write  = 1'b1;
                        bus.pc_write  = 1'b1;
                        bus.alu_src_b = 2'b01;
                    end
                end
                S_ID: begin
                    bus.alu_src_b = 2'b10;
                    if (is_jmp || is_jal) begin
                        bus.pc_write  = 1'b1;
                        bus.pc_source = 2'b10;
                    end
                    if (is_jpr || is_jrl) begin
                        bus.pc_write  = 1'b1;
                        bus.pc_source = 2'b11;
                    end
                    if (is_jal || is_jrl) begin
                        bus.reg_write  = 1'b1;
                        bus.reg_dst    = 2'b10;
                        bus.mem_to_reg = 2'b10;
                    end
                    bus.is_wwd = is_wwd_i;
                end
                S_EX: begin
                    bus.alu_src_a = 1'b1;
                    if (is_branch) begin
                        bus.alu_op        = ALUOP_W'(4'd10 + bus.opcode);
                        bus.pc_write_cond = 1'b1;
                        bus.pc_source     = 2'b01;
                    end else if (is_alu_r) begin
                        bus.alu_op = ALUOP_W'(bus.func_code[3:0]);
                    end else begin
                        bus.alu_src_b = 2'b10;
                        if (bus.opcode == OP_ORI)      bus.alu_op = ALUOP_W'(4'd3);
                        else if (bus.opcode == OP_LHI) bus.alu_op = ALUOP_W'(4'd8);
                    end
                end
                S_MEM: begin
                    bus.i_or_d    = 1'b1;
                    bus.mem_read  = is_lwd;
                    bus.mem_write = is_swd;
                end
                S_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.reg_dst    = is_rtype ? 2'b01 : 2'b00;
                    bus.mem_to_reg = is_lwd ? 2'b01 : 2'b00;
                end
                S_HALT:  bus.is_halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.state    = state_q;
    assign bus.num_inst = num_inst_q;
endmodule
